// File: rtl/adder_arbiter_if.sv
// Requester/consumer bundle for adder_arbiter: packed operand buses in,
// one-hot grant back, and the single tagged result slot out.
`timescale 1ns/1ps
interface adder_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       IN_valid;
  logic [NUM_REQ*WIDTH-1:0] IN_a;
  logic [NUM_REQ*WIDTH-1:0] IN_b;
  logic [NUM_REQ-1:0]       OUT_ready;
  logic                     OUT_valid;
  logic [WIDTH-1:0]         OUT_sum;
  logic                     OUT_carry;
  logic [ID_W-1:0]          OUT_id;
  logic                     IN_ready;
  logic [15:0]              OUT_opCount;

  modport master (
    output IN_valid, IN_a, IN_b, IN_ready,
    input  OUT_ready, OUT_valid, OUT_sum, OUT_carry, OUT_id, OUT_opCount
  );

  modport slave (
    input  IN_valid, IN_a, IN_b, IN_ready,
    output OUT_ready, OUT_valid, OUT_sum, OUT_carry, OUT_id, OUT_opCount
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter feeding one shared WIDTH-bit adder into a single
// registered result slot with a valid/ready handoff downstream.
`timescale 1ns/1ps
module adder_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
) (
  input  logic           clk,
  input  logic           rst,
  adder_arbiter_if.slave bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                valid_q, valid_d;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic                carry_q, carry_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [15:0]         op_count_q, op_count_d;

  logic                advance;
  logic                grant_any;
  logic [ID_W-1:0]     grant_idx;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [NUM_REQ-1:0]  rotated;
  logic [WIDTH-1:0]    a_sel;
  logic [WIDTH-1:0]    b_sel;
  int                  grant_pos;
  int                  next_pos;

  // Rotating the request vector by ptr turns the round-robin scan into a
  // plain lowest-bit-first search; the offset is then rotated back.
  always_comb begin
    advance   = !valid_q || bus.IN_ready;
    rotated   = NUM_REQ'({bus.IN_valid, bus.IN_valid} >> ptr_q);
    grant_any = 1'b0;
    grant_pos = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && rotated[k]) begin
        grant_any = 1'b1;
        grant_pos = int'(ptr_q) + k;
      end
    end
    if (grant_pos >= NUM_REQ) begin
      grant_pos = grant_pos - NUM_REQ;
    end
    if (!advance || rst) begin
      grant_any = 1'b0;
    end
    grant_idx = ID_W'(grant_pos);
    grant_oh  = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
    next_pos  = (grant_pos + 1 >= NUM_REQ) ? 0 : grant_pos + 1;
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        a_sel = bus.IN_a[i*WIDTH +: WIDTH];
        b_sel = bus.IN_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // An idle advance only empties the slot; the payload keeps its last value.
  always_comb begin
    valid_d    = valid_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    op_count_d = op_count_q;
    if (grant_any) begin
      {carry_d, sum_d} = {1'b0, a_sel} + {1'b0, b_sel};
      id_d             = grant_idx;
      valid_d          = 1'b1;
      ptr_d            = ID_W'(next_pos);
      op_count_d       = op_count_q + 16'd1;
    end else if (advance) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      id_q       <= '0;
      ptr_q      <= '0;
      op_count_q <= '0;
    end else begin
      valid_q    <= valid_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      op_count_q <= op_count_d;
    end
  end

  assign bus.OUT_ready   = grant_oh;
  assign bus.OUT_valid   = valid_q;
  assign bus.OUT_sum     = sum_q;
  assign bus.OUT_carry   = carry_q;
  assign bus.OUT_id      = id_q;
  assign bus.OUT_opCount = op_count_q;
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Round-robin scheduler that shares one WIDTH-bit adder datapath between NUM_REQ requesters.
- Each cycle it accepts at most one requester's operand pair and adds them.
- The result goes into a single registered output slot, tagged with the requester index, under a valid/ready handshake to one downstream consumer.
- Sits between independent issue sources and the shared adder; it is the only block driving that adder.

Parameters:
WIDTH, 8, operand and sum width in bits (>=1)
NUM_REQ, 4, number of requesters (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
IN_valid  in  NUM_REQ  requester i has an operand pair pending
IN_a  in  NUM_REQ*WIDTH  operand a; requester i at [i*WIDTH +: WIDTH]
IN_b  in  NUM_REQ*WIDTH  operand b; same packing
OUT_ready  out  NUM_REQ  one-hot grant; requester i's pair is consumed this cycle
OUT_valid  out  1  output slot holds a result
OUT_sum  out  WIDTH  (a+b) truncated to WIDTH bits
OUT_carry  out  1  bit WIDTH of a+b
OUT_id  out  max(1,$clog2(NUM_REQ))  index of the requester that produced OUT_sum
IN_ready  in  1  downstream accepts the output slot this cycle
OUT_opCount  out  16  total grants since reset, wraps modulo 2^16

Behaviour:
- Reset (async assert, sync release): OUT_valid=0, OUT_sum=0, OUT_carry=0, OUT_id=0, OUT_opCount=0, round-robin pointer ptr=0.
  - OUT_ready=0 while rst is high.
  - Reset mid-operation discards any held result without handing it off.
- Slot state is two-state, EMPTY (OUT_valid=0) / FULL (OUT_valid=1).
  - advance = !OUT_valid || IN_ready.
- Grant (combinational):
  - If advance and |IN_valid, g = first index with IN_valid set, scanning ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1.
  - OUT_ready = one-hot(g); otherwise OUT_ready=0.
  - OUT_ready may depend on IN_valid. Requesters must not make IN_valid depend on OUT_ready.
- On a clock edge with a grant:
  - OUT_sum <= IN_a[g]+IN_b[g] (low WIDTH bits).
  - OUT_carry <= carry out.
  - OUT_id <= g; OUT_valid <= 1.
  - ptr <= (g+1) mod NUM_REQ.
  - OUT_opCount <= OUT_opCount+1 (wraps 0xFFFF->0x0000).
- On a clock edge with advance and no IN_valid:
  - OUT_valid <= 0.
  - OUT_sum, OUT_carry and OUT_id hold their last values.
  - ptr is unchanged.
- On a clock edge without advance (FULL and !IN_ready): all state holds and OUT_ready=0 (stall).
- Latency and throughput:
  - Grant to OUT_valid is 1 cycle.
  - With IN_ready held high, sustained throughput is 1 result per cycle.
  - Handoff and a new grant happen in the same cycle (no bubble).
- Fairness: a requester holding IN_valid high is granted within NUM_REQ grants.
- Requester contract: a requester holds IN_valid, IN_a and IN_b stable until its OUT_ready bit is seen high. IN_valid dropping before grant is legal and simply withdraws the request.
- Output contract: OUT_sum, OUT_carry and OUT_id are stable while OUT_valid=1 and !IN_ready.
- Operands are unsigned. A carry beyond WIDTH+1 bits does not exist; a+b fits in WIDTH+1 bits.
- NUM_REQ=1: OUT_id is constant 0, ptr is constant 0, and the grant reduces to IN_valid[0] && advance.

Test Plan (WIDTH=8, NUM_REQ=4):
- Reset: assert rst mid-cycle while FULL -> outputs immediately OUT_valid=0, OUT_sum=0, OUT_id=0, OUT_opCount=0; OUT_ready=0 until release.
- Single requester: IN_valid=0b0100, a=0xF0, b=0x25, IN_ready=1 -> OUT_ready=0b0100 same cycle; next cycle OUT_valid=1, OUT_sum=0x15, OUT_carry=1, OUT_id=2, OUT_opCount=1.
- Round-robin: IN_valid=0b1111 held, IN_ready=1, 8 cycles -> OUT_id sequence 0,1,2,3,0,1,2,3 with no bubbles; opCount=8.
- Backpressure: result id=1 pending, IN_ready=0 for 3 cycles with IN_valid=0b0001 -> OUT_ready=0 and outputs frozen for 3 cycles. IN_ready=1 -> requester 0 granted that cycle; next cycle OUT_id=0.
- Pointer skip/wrap: after a grant to 3 (ptr=0), IN_valid=0b0110 -> grant 1; then grant 2; then IN_valid=0 with IN_ready=1 -> OUT_valid drops to 0 and ptr stays 3.
- Counter wrap: force 65535 grants then 1 more -> OUT_opCount goes 0xFFFF -> 0x0000.
